sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of byte entries in the output FIFO (power of 2, minimum 2).
REQ-002 Port clk_i SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 Port rst_i SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 Port data_i SHALL be an input, 1 bit wide, carrying one serial data bit, LSB of each byte first.
REQ-005 Port valid_i SHALL be an input, 1 bit wide, and is high when data_i carries a valid bit.
REQ-006 Port ready_o SHALL be an output, 1 bit wide, and is high when the module can accept a serial bit.
REQ-007 Port data_o SHALL be an output, 8 bits wide, carrying the assembled byte at the FIFO head.
REQ-008 Port valid_o SHALL be an output, 1 bit wide, and is high when data_o holds a valid byte.
REQ-009 Port ready_i SHALL be an input, 1 bit wide, and is high when the downstream consumer accepts data_o.

Function
REQ-010 A serial bit SHALL be accepted on a rising clk_i edge when valid_i=1 and ready_o=1; bits offered with ready_o=0 are not accepted and the sender holds them.
REQ-011 The n-th accepted bit of a byte (n=0..7) SHALL be stored into bit n of an 8-bit shift register; bit_cnt (0..7) SHALL increment on every accepted bit.
REQ-012 The FSM SHALL have exactly two states:
- S_IDLE: bit_cnt=0.
- S_SHIFT: 1..7 bits held.
REQ-013 S_IDLE -> S_SHIFT SHALL occur on an accepted bit; S_SHIFT stays until the 8th accepted bit.
REQ-014 On the 8th accepted bit, on the same edge:
- the completed byte (including that bit) SHALL be written into the FIFO;
- bit_cnt SHALL wrap to 0;
- the FSM SHALL return to S_IDLE.
REQ-015 ready_o SHALL equal (FIFO occupancy < DEPTH) while rst_i=0, derived from registered state only, with no combinational path from any input.
REQ-016 ready_o SHALL be low while the FIFO is full, in every FSM state, so a partial byte stalls rather than overflowing.
REQ-017 valid_o SHALL equal (FIFO occupancy > 0); data_o SHALL equal the FIFO head entry, driven from registers.
REQ-018 The FIFO head SHALL be popped on a rising edge when valid_o=1 and ready_i=1; data_o SHALL stay stable while valid_o=1 and ready_i=0.
REQ-019 Latency SHALL be one edge: a byte completed on edge k into an empty FIFO gives valid_o=1 with that byte on data_o immediately after edge k.
REQ-020 A simultaneous push and pop on one edge SHALL leave occupancy unchanged and lose no data; the popped byte is the old head.
REQ-021 A push and a pop on one edge with occupancy DEPTH-1 SHALL leave occupancy at DEPTH-1, so ready_o stays high.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; occupancy SHALL be log2(DEPTH)+1 bits and range 0..DEPTH.
REQ-023 Bytes SHALL leave in arrival order with no duplication or loss under any valid_i/ready_i pattern.

Reset
REQ-024 While rst_i=1, regardless of clk_i, the block SHALL hold:
- FSM=S_IDLE, bit_cnt=0, shift register=0;
- FIFO pointers=0, occupancy=0;
- data_o=8'h00, valid_o=0, ready_o=0.
REQ-025 Reset asserted mid-byte or with a non-empty FIFO SHALL discard the partial byte and all stored bytes; ready_o SHALL rise to 1 in the first cycle after rst_i deasserts.

Verification
REQ-026 The bench SHALL cover: after reset, with ready_i=1, send bits 1,0,1,0,0,1,0,1 (LSB first) -> valid_o=1 and data_o=8'hA5 one edge after the 8th bit, popped on the next edge.
REQ-027 The bench SHALL cover: ready_i=0, stream 4 bytes 8'h01,8'h02,8'h03,8'h04 (DEPTH=4) -> ready_o=0 after the 4th byte, the first bit of the 5th byte is held off, then ready_i=1 -> outputs 01,02,03,04 in order and ready_o returns to 1.
REQ-028 The bench SHALL cover: valid_i toggled randomly mid-byte with 8'h3C -> idle cycles add no bits and data_o=8'h3C.
REQ-029 The bench SHALL cover: FIFO at DEPTH-1 with ready_i=1 while the 8th bit of 8'hFF arrives -> push and pop on the same edge, occupancy unchanged, no loss.
REQ-030 The bench SHALL cover: rst_i pulsed asynchronously (between edges) after 5 bits of a byte -> valid_o=0 and data_o=0 immediately; the next 8 bits 8'h5A produce exactly 8'h5A.
REQ-031 The bench SHALL cover: a 16-byte random stream with random ready_i -> scoreboard matches in order and pointers wrap with no error.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out byte receiver with a small output FIFO.
// Bits arrive LSB first; completed bytes queue until the consumer takes them.
module sipo_rx #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [2:0]     bit_cnt;
  logic [7:0]     sr;
  logic [7:0]     sr_nx;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [AW:0]    count_nx;
  logic           ready_q;
  logic           acc;
  logic           last;
  logic           push;
  logic           pop;

  assign acc     = valid_i & ready_q;
  assign last    = (bit_cnt == 3'd7);
  assign push    = acc & last;
  assign pop     = valid_o & ready_i;
  assign valid_o = (count != '0);
  assign data_o  = mem[rd_ptr];
  assign ready_o = ready_q;

  // Byte image including the bit accepted this cycle
  always_comb begin
    sr_nx = sr;
    if (acc) sr_nx[bit_cnt] = data_i;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (acc) state_nx = S_SHIFT;
      S_SHIFT: if (push) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        bit_cnt <= bit_cnt + 3'd1;
        sr      <= sr_nx;
      end
    end
  end

  // ready is registered from the next occupancy so it never sees inputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count   <= count_nx;
      ready_q <= (count_nx < FULL);
      if (push) begin
        mem[wr_ptr] <= sr_nx;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: reset, byte assembly, backpressure,
// gaps, simultaneous push/pop, async reset and a random stream.
module tb_sipo_rx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       data_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  bit done;

  sipo_rx #(.DEPTH(4)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Log every byte that will be popped at the coming rising edge
  always begin
    @(negedge clk_i);
    #2;
    if (!rst_i && valid_o && ready_i) got.push_back(data_o);
  end

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    data_i = b;
    valid_i = 1'b1;
    while (!ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n == 100) begin
      tests++;
      fails++;
      $display("FAIL send_bit_timeout got ready_o=%b want 1", ready_o);
    end
    @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          valid_i = 1'b0;
          data_i = 1'($urandom_range(0, 1));
          @(negedge clk_i);
        end
      end
      send_bit(v[i]);
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_got(input int n, input string name);
    int c;
    c = 0;
    while (got.size() < n && c < 200) begin
      @(negedge clk_i);
      c++;
    end
    tests++;
    if (got.size() != n) begin
      fails++;
      $display("FAIL %s_count got %0d want %0d", name, got.size(), n);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid got %b want 0", valid_o);
    end
    tests++;
    if (ready_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_ready got %b want 0", ready_o);
    end
    tests++;
    if (data_o !== 8'h00) begin
      fails++;
      $display("FAIL rst_data got %h want 00", data_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    tests++;
    if (ready_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_ready_rise got %b want 1", ready_o);
    end
  endtask

  task automatic test_a5();
    got.delete();
    ready_i = 1'b1;
    send_byte(8'hA5, 1'b0);
    tests++;
    if (valid_o !== 1'b1 || data_o !== 8'hA5) begin
      fails++;
      $display("FAIL a5_out got v=%b d=%h want v=1 d=a5", valid_o, data_o);
    end
    @(negedge clk_i);
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL a5_pop got v=%b want 0", valid_o);
    end
    wait_got(1, "a5");
    if (got.size() > 0) chk("a5_popped", got[0], 8'hA5);
  endtask

  task automatic test_full();
    got.delete();
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    tests++;
    if (ready_o !== 1'b0) begin
      fails++;
      $display("FAIL full_ready got %b want 0", ready_o);
    end
    chk("full_head", data_o, 8'h01);
    data_i = 1'b1;
    valid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    tests++;
    if (ready_o !== 1'b0 || data_o !== 8'h01 || valid_o !== 1'b1) begin
      fails++;
      $display("FAIL full_hold got r=%b v=%b d=%h want r=0 v=1 d=01",
               ready_o, valid_o, data_o);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    wait_got(4, "full");
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("full_order", got[i], 8'(i + 1));
    @(negedge clk_i);
    tests++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL full_drain got r=%b v=%b want r=1 v=0", ready_o, valid_o);
    end
  endtask

  task automatic test_gaps();
    got.delete();
    ready_i = 1'b1;
    send_byte(8'h3C, 1'b1);
    wait_got(1, "gaps");
    if (got.size() > 0) chk("gaps_data", got[0], 8'h3C);
  endtask

  task automatic test_simul();
    got.delete();
    ready_i = 1'b0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    ready_i = 1'b1;
    send_bit(1'b1);
    ready_i = 1'b0;
    valid_i = 1'b0;
    tests++;
    if (ready_o !== 1'b1 || valid_o !== 1'b1) begin
      fails++;
      $display("FAIL simul_flags got r=%b v=%b want r=1 v=1", ready_o, valid_o);
    end
    chk("simul_head", data_o, 8'h22);
    chk("simul_one_pop", 8'(got.size()), 8'd1);
    ready_i = 1'b1;
    wait_got(4, "simul");
    exp_q = '{8'h11, 8'h22, 8'h33, 8'hFF};
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("simul_order", got[i], exp_q[i]);
    @(negedge clk_i);
  endtask

  task automatic test_async_reset();
    ready_i = 1'b0;
    send_byte(8'h77, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    valid_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    tests++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || ready_o !== 1'b0) begin
      fails++;
      $display("FAIL arst_now got v=%b d=%h r=%b want v=0 d=00 r=0",
               valid_o, data_o, ready_o);
    end
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    tests++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL arst_after got r=%b v=%b want r=1 v=0", ready_o, valid_o);
    end
    got.delete();
    ready_i = 1'b1;
    send_byte(8'h5A, 1'b0);
    wait_got(1, "arst");
    if (got.size() > 0) chk("arst_data", got[0], 8'h5A);
    @(negedge clk_i);
  endtask

  task automatic test_random();
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send_byte(exp_q[i], 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk_i);
          ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    ready_i = 1'b1;
    wait_got(16, "rand");
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk("rand_order", got[i], exp_q[i]);
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_a5();
    test_full();
    test_gaps();
    test_simul();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
